// File: rtl/vga_tile_ctrl.sv
// Parametrised VGA timing generator with tile-mapped framebuffer fetch and a
// sync/data alignment pipeline. Optional blinking tile cursor: VGA_CURSOR_EN.
module vga_tile_ctrl #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int HS_POL    = 0,
   parameter int VS_POL    = 0,
   parameter int TILE_LOG2 = 6,
   parameter int ADDR_W    = 8,
   parameter int ADDR_BASE = 128,
   parameter int CB        = 2,
   parameter int OUT_W     = 4,
   parameter int RD_LAT    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pix_en,
   input  logic [3*CB-1:0]   vdata,
   output logic [ADDR_W-1:0] vaddr,
   output logic [OUT_W-1:0]  VGA_R,
   output logic [OUT_W-1:0]  VGA_G,
   output logic [OUT_W-1:0]  VGA_B,
   output logic              VGA_HS_O,
   output logic              VGA_VS_O,
   output logic              de,
   output logic              frame_start,
   input  logic [7:0]        cursor_col,
   input  logic [7:0]        cursor_row
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int TILE    = 1 << TILE_LOG2;
   localparam int COLS    = (H_ACTIVE + TILE - 1) / TILE;
   localparam int D       = RD_LAT + 2;

   logic [HW-1:0] hcnt;
   logic [VW-1:0] vcnt;
   logic [HW-1:0] col;
   logic [VW-1:0] row;
   logic [31:0]   addr_full;
   logic          raw_de, raw_hs, raw_vs, raw_fs, cur_hit;
   logic [D-1:0]  de_d, hs_d, vs_d, fs_d, cur_d;
   logic [3*CB-1:0] pix;
   logic [OUT_W-1:0] r_pad, g_pad, b_pad;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (pix_en) begin
         if (hcnt == HW'(H_TOTAL - 1)) begin
            hcnt <= '0;
            vcnt <= (vcnt == VW'(V_TOTAL - 1)) ? '0 : vcnt + 1'b1;
         end else begin
            hcnt <= hcnt + 1'b1;
         end
      end
   end

   always_comb begin
      col       = hcnt >> TILE_LOG2;
      row       = vcnt >> TILE_LOG2;
      addr_full = 32'(ADDR_BASE) + 32'(row) * 32'(COLS) + 32'(col);
      raw_de    = (32'(hcnt) < 32'(H_ACTIVE)) && (32'(vcnt) < 32'(V_ACTIVE));
      raw_hs    = (32'(hcnt) >= 32'(H_ACTIVE + H_FP)) &&
                  (32'(hcnt) <  32'(H_ACTIVE + H_FP + H_SYNC));
      raw_vs    = (32'(vcnt) >= 32'(V_ACTIVE + V_FP)) &&
                  (32'(vcnt) <  32'(V_ACTIVE + V_FP + V_SYNC));
      raw_fs    = (hcnt == '0) && (vcnt == '0);
`ifdef VGA_CURSOR_EN
      cur_hit   = (32'(col) == 32'(cursor_col)) && (32'(row) == 32'(cursor_row));
`else
      cur_hit   = 1'b0;
`endif
   end

`ifndef VGA_CURSOR_EN
   logic unused_cursor;
   assign unused_cursor = ^{cursor_col, cursor_row};
`endif

   // Raw timing signals travel through D stages so they meet RGB at the pins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vaddr <= ADDR_W'(ADDR_BASE);
         de_d  <= '0;
         hs_d  <= '0;
         vs_d  <= '0;
         fs_d  <= '0;
         cur_d <= '0;
      end else if (pix_en) begin
         vaddr <= addr_full[ADDR_W-1:0];
         de_d  <= {de_d[D-2:0], raw_de};
         hs_d  <= {hs_d[D-2:0], raw_hs};
         vs_d  <= {vs_d[D-2:0], raw_vs};
         fs_d  <= {fs_d[D-2:0], raw_fs};
         cur_d <= {cur_d[D-2:0], cur_hit};
      end
   end

`ifdef VGA_CURSOR_EN
   logic [5:0] fcnt;
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         fcnt <= '0;
      else if (pix_en && fs_d[D-1])
         fcnt <= fcnt + 1'b1;
   end
`endif

   // Inversion acts on the colour index before MSB alignment, so pad bits stay 0.
   always_comb begin
      pix = vdata;
`ifdef VGA_CURSOR_EN
      if (cur_d[D-2] && fcnt[5])
         pix = ~vdata;
`endif
      r_pad = '0;
      g_pad = '0;
      b_pad = '0;
      r_pad[OUT_W-1 -: CB] = pix[3*CB-1:2*CB];
      g_pad[OUT_W-1 -: CB] = pix[2*CB-1:CB];
      b_pad[OUT_W-1 -: CB] = pix[CB-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         VGA_R <= '0;
         VGA_G <= '0;
         VGA_B <= '0;
      end else if (pix_en) begin
         if (de_d[D-2]) begin
            VGA_R <= r_pad;
            VGA_G <= g_pad;
            VGA_B <= b_pad;
         end else begin
            VGA_R <= '0;
            VGA_G <= '0;
            VGA_B <= '0;
         end
      end
   end

   assign de          = de_d[D-1];
   assign frame_start = fs_d[D-1];
   assign VGA_HS_O    = hs_d[D-1] ^ (HS_POL == 0);
   assign VGA_VS_O    = vs_d[D-1] ^ (VS_POL == 0);

endmodule
